// File: rtl/mem_controller.sv
// ---------------------------------------------------------------------------
// mem_controller
//
// Shares one single-port synchronous RAM between the instruction fetch stage
// and the memory (data) stage. Requests are serialised onto the RAM port, and
// data accesses always win arbitration over fetches. Each requester gets a
// one-cycle ready pulse when its access completes. The requester holds its
// request until that pulse and must drop or replace it in the ready cycle.
//
// Optional feature macro: MC_ALIGN_CHECK_EN
//   defined   : a data access with addr[1:0] != 0 never touches the RAM. It
//               completes one cycle after accept with mc_mem_err and
//               mc_mem_ready pulsing together.
//   undefined : low address bits are ignored everywhere, and mc_mem_err
//               is constant 0.
//
// Parameters
//   ADDR_WIDTH : RAM word-address width (depth = 2**ADDR_WIDTH words)
//   LATENCY    : cycles from mc_ram_en to ready (>= 2)
//
// Ports
//   clock, reset          : rising-edge clock, async active-low reset
//   if_mc_en/addr         : fetch read request (level) and byte address
//   mc_if_data/ready      : fetched word (held) and completion pulse
//   mem_mc_rd/wr/addr/data: data request (level), byte address, write data
//   mc_mem_data/ready/err : read data (held), completion pulse, misalign pulse
//   mc_ram_*              : RAM enable, write strobe, word address, write data
//   ram_mc_rdata          : RAM read data
// ---------------------------------------------------------------------------
module mem_controller #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  // fetch port
  input  logic                  if_mc_en,
  input  logic [31:0]           if_mc_addr,
  output logic [31:0]           mc_if_data,
  output logic                  mc_if_ready,
  // data port
  input  logic                  mem_mc_rd,
  input  logic                  mem_mc_wr,
  input  logic [31:0]           mem_mc_addr,
  input  logic [31:0]           mem_mc_data,
  output logic [31:0]           mc_mem_data,
  output logic                  mc_mem_ready,
  output logic                  mc_mem_err,
  // RAM port
  output logic                  mc_ram_en,
  output logic                  mc_ram_wr,
  output logic [ADDR_WIDTH-1:0] mc_ram_addr,
  output logic [31:0]           mc_ram_wdata,
  input  logic [31:0]           ram_mc_rdata
);

  localparam int CW = $clog2(LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  // Access latched at accept; BUSY cycles only look at this copy.
  typedef struct packed {
    logic                  wr;
    logic                  err;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } req_t;

  state_t        state, state_nxt;
  req_t          req_q;
  logic [CW-1:0] cnt;
  logic          err_q;

  logic          mem_req;
  logic          misaligned;
  logic          accept_if, accept_mem;
  logic          done;
  logic          first_cycle;

  assign mem_req = mem_mc_rd | mem_mc_wr;

`ifdef MC_ALIGN_CHECK_EN
  assign misaligned = mem_req & (|mem_mc_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // Bits outside the word-address window are intentionally ignored
  // (addresses wrap modulo the RAM size).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_mc_addr[31:ADDR_WIDTH+2], if_mc_addr[1:0],
                              mem_mc_addr[31:ADDR_WIDTH+2], mem_mc_addr[1:0]};

  // The counter sits at LATENCY-1 only in the first BUSY cycle, because it is
  // loaded on accept and decrements every BUSY cycle after that.
  assign first_cycle = (state != IDLE) && (cnt == CNT_LOAD);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    accept_if  = 1'b0;
    accept_mem = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // Data first. A losing fetch stays asserted and is picked up later.
        if (mem_req) begin
          accept_mem = 1'b1;
          state_nxt  = BUSY_MEM;
        end else if (if_mc_en) begin
          accept_if = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        // A misaligned access finishes after its single (RAM-less) cycle.
        if (cnt == '0 || req_q.err) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: request latch, counter, read capture, ready pulses
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_q        <= '0;
      cnt          <= '0;
      mc_if_data   <= '0;
      mc_mem_data  <= '0;
      mc_if_ready  <= 1'b0;
      mc_mem_ready <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      mc_if_ready  <= 1'b0;
      mc_mem_ready <= 1'b0;
      err_q        <= 1'b0;
      if (accept_mem) begin
        req_q.wr    <= mem_mc_wr;
        req_q.err   <= misaligned;
        req_q.addr  <= mem_mc_addr[ADDR_WIDTH+1:2];
        req_q.wdata <= mem_mc_data;
        cnt         <= CNT_LOAD;
      end else if (accept_if) begin
        // Write data is kept as-is; it is never strobed for a fetch.
        req_q.wr    <= 1'b0;
        req_q.err   <= 1'b0;
        req_q.addr  <= if_mc_addr[ADDR_WIDTH+1:2];
        cnt         <= CNT_LOAD;
      end else if (done) begin
        cnt <= '0;
        if (state == BUSY_IF) begin
          mc_if_data  <= ram_mc_rdata;
          mc_if_ready <= 1'b1;
        end else begin
          if (!req_q.wr && !req_q.err) mc_mem_data <= ram_mc_rdata;
          mc_mem_ready <= 1'b1;
          err_q        <= req_q.err;
        end
      end else if (state != IDLE) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // RAM port. The enable is gated with reset so that it drops the instant
  // reset asserts, independent of the flops.
  // ---------------------------------------------------------------------
  assign mc_ram_en    = reset & first_cycle & ~req_q.err;
  assign mc_ram_wr    = mc_ram_en & req_q.wr;
  assign mc_ram_addr  = req_q.addr;
  assign mc_ram_wdata = req_q.wdata;

  // err_q can only be set when the alignment check is built in.
  assign mc_mem_err   = err_q;

endmodule
